// File: rtl/mmm_hard_core.sv
// Maximum-clique enumerator: loads header + adjacency rows, bounded DFS one node/cycle, streams header + packed vertex IDs.
// Latency data-dependent; input want only in IDLE/LOAD, output word registered and held until the consumer takes it.
module mmm_hard_core #(
    parameter int MAX_V       = 64,
    parameter int MAX_CLIQUES = 64
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_indata,
    input  logic        i_indata_ready,
    output logic        o_indata_want,
    output logic [31:0] o_outdata,
    output logic        o_outdata_ready,
    input  logic        i_outdata_want
);
    localparam int VW = $clog2(MAX_V);
    localparam int DW = $clog2(MAX_V + 1);
    localparam int KW = $clog2(MAX_CLIQUES + 1);
    localparam int SW = $clog2(MAX_CLIQUES);
    localparam int RW = MAX_V / 32;

    typedef enum logic [2:0] {IDLE, LOAD, SEARCH, SEND_HDR, SEND_BODY} state_t;
    state_t state;

    logic [MAX_V-1:0] adj      [MAX_V];
    logic [MAX_V-1:0] cand_stk [MAX_V+1];
    logic [VW-1:0]    vert_stk [MAX_V];
    logic [MAX_V-1:0] store    [MAX_CLIQUES];
    logic [MAX_V-1:0] cur_mask, valid_mask;
    logic [DW-1:0]    depth;
    logic [15:0]      n_vert, best, row, col, row_words, ids_left;
    logic [KW-1:0]    n_cliq, out_k;
    logic [MAX_V-1:0] out_mask;

    function automatic logic [VW-1:0] lsb_idx(input logic [MAX_V-1:0] m);
        lsb_idx = '0;
        for (int i = MAX_V - 1; i >= 0; i--)
            if (m[i]) lsb_idx = VW'(i);
    endfunction

    function automatic logic [15:0] popcnt(input logic [MAX_V-1:0] m);
        popcnt = '0;
        for (int i = 0; i < MAX_V; i++) popcnt = popcnt + 16'(m[i]);
    endfunction

    function automatic logic [MAX_V-1:0] onehot(input logic [VW-1:0] idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction

    logic in_fire, out_fire, hdr_fire, load_fire, last_word;
    assign in_fire   = i_indata_ready && o_indata_want;
    assign out_fire  = o_outdata_ready && i_outdata_want;
    assign hdr_fire  = in_fire && (state == IDLE);
    assign load_fire = in_fire && (state == LOAD);
    assign last_word = (row == n_vert - 16'd1) && (col == row_words - 16'd1);

    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < MAX_V; i++) valid_mask[i] = (i < int'(n_vert));
    end

    // Search step: the lowest remaining candidate extends the clique; its children are later
    // candidates that are also its neighbours, so every member stays mutually adjacent.
    logic [MAX_V-1:0] top, top_rest, v_bit;
    logic [VW-1:0]    v;
    logic [15:0]      size_next;
    logic             prune, expand;
    always_comb begin
        top       = cand_stk[depth];
        v         = lsb_idx(top);
        v_bit     = onehot(v);
        top_rest  = top & ~v_bit;
        size_next = 16'(depth) + 16'd1;
        prune     = (16'(depth) + popcnt(top)) < best;
        expand    = (state == SEARCH) && (top != '0) && !prune;
    end

    // Output walker: pulls two vertex IDs per word, rolling into the next stored clique when one empties.
    logic [VW-1:0]    id0, id1;
    logic [MAX_V-1:0] mask_a, mask_b;
    logic [KW-1:0]    k_a, k_b;
    logic [31:0]      body_word;
    logic [15:0]      ids_next;
    always_comb begin
        id0    = lsb_idx(out_mask);
        mask_a = out_mask & ~onehot(id0);
        k_a    = out_k;
        if (mask_a == '0) begin
            k_a    = out_k + 1'b1;
            mask_a = (k_a < KW'(MAX_CLIQUES)) ? store[k_a[SW-1:0]] : '0;
        end
        id1    = lsb_idx(mask_a);
        mask_b = mask_a & ~onehot(id1);
        k_b    = k_a;
        if (mask_b == '0) begin
            k_b    = k_a + 1'b1;
            mask_b = (k_b < KW'(MAX_CLIQUES)) ? store[k_b[SW-1:0]] : '0;
        end
        if (ids_left >= 16'd2) begin
            body_word = {{(16-VW){1'b0}}, id1, {(16-VW){1'b0}}, id0};
            ids_next  = ids_left - 16'd2;
        end else begin
            body_word = {16'd0, {(16-VW){1'b0}}, id0};
            ids_next  = 16'd0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (hdr_fire) cand_stk[0] <= '0;
        if (load_fire) begin
            for (int w = 0; w < RW; w++)
                if (row < 16'(MAX_V) && col == 16'(w))
                    adj[row[VW-1:0]][w*32 +: 32] <= i_indata;
            if (last_word) cand_stk[0] <= valid_mask;
        end
        if (expand) begin
            cand_stk[depth]        <= top_rest;
            cand_stk[depth + 1'b1] <= top_rest & adj[v];
            vert_stk[VW'(depth)]   <= v;
            if (size_next > best)
                store[0] <= cur_mask | v_bit;
            else if (size_next == best && n_cliq < KW'(MAX_CLIQUES))
                store[n_cliq[SW-1:0]] <= cur_mask | v_bit;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= IDLE;
            o_indata_want   <= 1'b0;
            o_outdata_ready <= 1'b0;
            o_outdata       <= '0;
            n_vert          <= '0;
            best            <= '0;
            row             <= '0;
            col             <= '0;
            row_words       <= '0;
            n_cliq          <= '0;
            depth           <= '0;
            cur_mask        <= '0;
            out_k           <= '0;
            out_mask        <= '0;
            ids_left        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_indata_want <= 1'b1;
                    if (in_fire) begin
                        n_vert    <= i_indata[31:16];
                        best      <= i_indata[15:0];
                        row_words <= 16'((17'(i_indata[31:16]) + 17'd31) >> 5);
                        row       <= '0;
                        col       <= '0;
                        n_cliq    <= '0;
                        depth     <= '0;
                        cur_mask  <= '0;
                        if (i_indata[31:16] == 16'd0) begin
                            state         <= SEARCH;
                            o_indata_want <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: if (in_fire) begin
                    if (col == row_words - 16'd1) begin
                        col <= '0;
                        row <= row + 16'd1;
                        if (last_word) begin
                            state         <= SEARCH;
                            o_indata_want <= 1'b0;
                        end
                    end else begin
                        col <= col + 16'd1;
                    end
                end
                SEARCH: if (expand) begin
                    depth    <= depth + 1'b1;
                    cur_mask <= cur_mask | v_bit;
                    if (size_next > best) begin
                        best   <= size_next;
                        n_cliq <= KW'(1);
                    end else if (size_next == best && n_cliq < KW'(MAX_CLIQUES)) begin
                        n_cliq <= n_cliq + 1'b1;
                    end
                end else if (depth == '0) begin
                    o_outdata       <= {best, 16'(n_cliq)};
                    o_outdata_ready <= 1'b1;
                    out_k           <= '0;
                    out_mask        <= store[0];
                    ids_left        <= 16'(32'(n_cliq) * 32'(best));
                    state           <= SEND_HDR;
                end else begin
                    depth    <= depth - 1'b1;
                    cur_mask <= cur_mask & ~onehot(vert_stk[VW'(depth - 1'b1)]);
                end
                SEND_HDR, SEND_BODY: if (out_fire) begin
                    if (ids_left == 16'd0) begin
                        o_outdata_ready <= 1'b0;
                        o_outdata       <= '0;
                        o_indata_want   <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        o_outdata <= body_word;
                        ids_left  <= ids_next;
                        out_k     <= k_b;
                        out_mask  <= mask_b;
                        state     <= SEND_BODY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmm_hard_core.sv
// Scoreboard bench for mmm_hard_core: fixed graphs with known results plus brute-force-modelled random graphs.
module tb_mmm_hard_core;
    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [31:0] i_indata;
    logic        i_indata_ready;
    logic        o_indata_want;
    logic [31:0] o_outdata;
    logic        o_outdata_ready;
    logic        i_outdata_want;

    mmm_hard_core #(.MAX_V(64), .MAX_CLIQUES(64)) dut (
        .i_clk           (i_clk),
        .i_reset_n       (i_reset_n),
        .i_indata        (i_indata),
        .i_indata_ready  (i_indata_ready),
        .o_indata_want   (o_indata_want),
        .o_outdata       (o_outdata),
        .o_outdata_ready (o_outdata_ready),
        .i_outdata_want  (i_outdata_want)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          errors = 0;
    bit          in_stall = 0;
    bit          out_stall = 0;
    logic [31:0] exp_q[$];
    logic [127:0] g [128];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_graph();
        for (int i = 0; i < 128; i++) g[i] = '0;
    endtask

    task automatic add_edge(input int a, input int b);
        g[a][b] = 1'b1;
        g[b][a] = 1'b1;
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] x);
        for (int i = 0; i < 16; i++) rev16[15-i] = x[i];
    endfunction

    function automatic bit is_clique(input int m, input int n);
        for (int i = 0; i < n; i++)
            if (m[i])
                for (int j = i + 1; j < n; j++)
                    if (m[j] && !g[i][j]) return 1'b0;
        return 1'b1;
    endfunction

    // Exhaustive subset scan (n <= 16), lexicographic sort, then pack into expected words.
    task automatic model_push(input int n, input int init);
        int          best;
        logic [15:0] found[$];
        logic [15:0] t;
        int          ids[$];
        best = init;
        for (int m = 1; m < (1 << n); m++) begin
            int sz = $countones(m);
            if (sz < best || !is_clique(m, n)) continue;
            if (sz > best) begin
                best = sz;
                found.delete();
            end
            found.push_back(16'(m));
        end
        for (int i = 1; i < found.size(); i++)
            for (int j = i; j > 0 && rev16(found[j]) > rev16(found[j-1]); j--) begin
                t = found[j]; found[j] = found[j-1]; found[j-1] = t;
            end
        while (found.size() > 64) void'(found.pop_back());
        foreach (found[k])
            for (int vtx = 0; vtx < n; vtx++)
                if (found[k][vtx]) ids.push_back(vtx);
        exp_q.push_back({16'(best), 16'(found.size())});
        for (int i = 0; i < ids.size(); i += 2)
            exp_q.push_back({(i + 1 < ids.size()) ? 16'(ids[i+1]) : 16'd0, 16'(ids[i])});
    endtask

    task automatic send_word(input logic [31:0] w);
        int c = 0;
        if (in_stall && $urandom_range(0, 2) == 0) begin
            i_indata_ready = 1'b0;
            i_indata = $urandom;
            @(posedge i_clk); #1;
        end
        i_indata = w;
        i_indata_ready = 1'b1;
        @(negedge i_clk);
        while (!o_indata_want && c < 20000) begin
            @(negedge i_clk);
            c++;
        end
        if (!o_indata_want) check_eq("in_wait", 32'(o_indata_want), 32'd1);
        @(posedge i_clk); #1;
    endtask

    task automatic send_problem(input int n, input int init);
        int c = (n + 31) / 32;
        send_word({n[15:0], init[15:0]});
        for (int i = 0; i < n; i++)
            for (int j = 0; j < c; j++)
                send_word(g[i][32*j +: 32]);
        i_indata_ready = 1'b0;
    endtask

    task automatic rand_graph(input int n);
        clear_graph();
        for (int i = 0; i < n; i++)
            for (int j = i + 1; j < n; j++)
                if ($urandom_range(0, 99) < 60) add_edge(i, j);
        for (int i = 0; i < n; i++) begin
            g[i][i] = 1'($urandom_range(0, 1));
            for (int k = n; k < 32; k++) g[i][k] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_drain(input int budget);
        int c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            @(posedge i_clk);
            c++;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_outdata_want = 1'b1;
        forever begin
            @(posedge i_clk); #1;
            i_outdata_want = out_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on every transfer and checks stall stability.
    initial begin
        logic [31:0] held;
        bit          held_vld;
        held_vld = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_reset_n) begin
                held_vld = 1'b0;
                continue;
            end
            if (held_vld) begin
                check_eq("hold_ready", 32'(o_outdata_ready), 32'd1);
                check_eq("hold_word", o_outdata, held);
            end
            held_vld = 1'b0;
            if (o_outdata_ready) begin
                if (i_outdata_want) begin
                    if (exp_q.size() == 0) check_eq("spurious_out", 32'(o_outdata_ready), 32'd0);
                    else check_eq("out_word", o_outdata, exp_q.pop_front());
                end else begin
                    held = o_outdata;
                    held_vld = 1'b1;
                end
            end
        end
    end

    initial begin
        i_reset_n = 1'b0;
        i_indata = '0;
        i_indata_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_eq("rst_want", 32'(o_indata_want), 32'd0);
        check_eq("rst_ready", 32'(o_outdata_ready), 32'd0);
        check_eq("rst_data", o_outdata, 32'd0);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        check_eq("want_after_rst", 32'(o_indata_want), 32'd1);

        clear_graph(); add_edge(0, 1); add_edge(0, 2); add_edge(1, 2);
        exp_q.push_back(32'h0003_0001); exp_q.push_back(32'h0001_0000); exp_q.push_back(32'h0000_0002);
        send_problem(3, 1);

        clear_graph();
        exp_q.push_back(32'h0001_0003); exp_q.push_back(32'h0001_0000); exp_q.push_back(32'h0000_0002);
        send_problem(3, 1);

        clear_graph(); add_edge(0, 1); add_edge(2, 3);
        exp_q.push_back(32'h0002_0002); exp_q.push_back(32'h0001_0000); exp_q.push_back(32'h0003_0002);
        send_problem(4, 1);

        clear_graph(); add_edge(0, 1); add_edge(0, 2); add_edge(1, 2);
        exp_q.push_back(32'h0005_0000);
        send_problem(3, 5);

        clear_graph(); add_edge(0, 32); add_edge(1, 32);
        exp_q.push_back(32'h0002_0002); exp_q.push_back(32'h0020_0000); exp_q.push_back(32'h0020_0001);
        send_problem(33, 1);

        clear_graph(); add_edge(1, 2); add_edge(2, 3); add_edge(1, 3);
        for (int a = 65; a < 69; a++)
            for (int b = a + 1; b < 69; b++) add_edge(a, b);
        exp_q.push_back(32'h0003_0001); exp_q.push_back(32'h0002_0001); exp_q.push_back(32'h0000_0003);
        send_problem(70, 1);

        exp_q.push_back(32'h0002_0000);
        send_problem(0, 2);

        // 128 maximum cliques of size 7: result store saturates at 64
        clear_graph();
        for (int i = 0; i < 14; i++)
            for (int j = i + 1; j < 14; j++)
                if (i / 2 != j / 2) add_edge(i, j);
        model_push(14, 1);
        send_problem(14, 1);
        wait_drain(30000);

        in_stall = 1'b1;
        out_stall = 1'b1;
        for (int p = 0; p < 5; p++) begin
            int n = $urandom_range(4, 12);
            int init = $urandom_range(1, 3);
            rand_graph(n);
            model_push(n, init);
            send_problem(n, init);
        end
        wait_drain(20000);

        rand_graph(8);
        send_word(32'h0008_0001);
        for (int i = 0; i < 5; i++) send_word(g[i][31:0]);
        i_indata_ready = 1'b0;
        i_reset_n = 1'b0;
        #1;
        check_eq("abort_want", 32'(o_indata_want), 32'd0);
        check_eq("abort_ready", 32'(o_outdata_ready), 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        check_eq("restart_want", 32'(o_indata_want), 32'd1);

        for (int p = 0; p < 3; p++) begin
            int n = $urandom_range(5, 10);
            rand_graph(n);
            model_push(n, 1);
            send_problem(n, 1);
        end
        wait_drain(20000);
        @(negedge i_clk);
        check_eq("idle_want", 32'(o_indata_want), 32'd1);
        check_eq("idle_ready", 32'(o_outdata_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
